// File: rtl/bitwise_logic_unit.sv
// Bitwise logic unit: AND/OR/XOR plus a sticky AND-accumulator, behind a one-deep valid/ready output register.
// Optional macro BLU_REDUCE_EN adds registered Zero_o / Ones_o flags for the loaded result.
module bitwise_logic_unit #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] A_i,
  input  logic [W-1:0] B_i,
  input  logic [1:0]   Op_i,
  input  logic         Clr_i,
  input  logic         Valid_i,
  output logic         Ready_o,
  output logic [W-1:0] Z_o,
  output logic         Valid_o,
`ifdef BLU_REDUCE_EN
  output logic         Zero_o,
  output logic         Ones_o,
`endif
  input  logic         Ready_i
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  logic [W-1:0] z_d, z_q;
  logic [W-1:0] acc_d, acc_q;
  logic         valid_d, valid_q;
  logic         accept_s;

`ifdef BLU_REDUCE_EN
  logic zero_d, zero_q;
  logic ones_d, ones_q;
`endif

  assign Ready_o  = ~valid_q | Ready_i;
  assign accept_s = Valid_i & Ready_o;
  assign Z_o      = z_q;
  assign Valid_o  = valid_q;

  // Next-state: load a new result on accept, drain on transfer, hold on stall.
  always_comb begin
    z_d     = z_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    if (accept_s) begin
      valid_d = 1'b1;
      case (Op_i)
        OP_AND: z_d = A_i & B_i;
        OP_OR:  z_d = A_i | B_i;
        OP_XOR: z_d = A_i ^ B_i;
        OP_ACC: begin
          acc_d = (Clr_i ? {W{1'b0}} : acc_q) | (A_i & B_i);
          z_d   = acc_d;
        end
        default: z_d = {W{1'b0}};
      endcase
    end else if (Ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

`ifdef BLU_REDUCE_EN
  // Flags follow the result only when a new result is loaded, so they hold during stalls.
  always_comb begin
    zero_d = zero_q;
    ones_d = ones_q;
    if (accept_s) begin
      zero_d = (z_d == {W{1'b0}});
      ones_d = (z_d == {W{1'b1}});
    end else begin
      zero_d = zero_q;
      ones_d = ones_q;
    end
  end

  assign Zero_o = zero_q;
  assign Ones_o = ones_q;

  // Reduction flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
      ones_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ones_q <= ones_d;
    end
  end
`endif

  // Result, accumulator and valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q     <= {W{1'b0}};
      acc_q   <= {W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      z_q     <= z_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
    end
  end

endmodule
